// File: rtl/chain_count.sv
// chain_count: DIGITS cascaded modulo-M_PARAM up/down digits with a whole-chain rollover (ro) and borrow (bo).
// Define CHAIN_COUNT_SAT_EN to make the chain saturate at its ends instead of wrapping; this also adds the sat output.
module chain_count #(
   parameter int M_PARAM = 10,
   parameter int DIGIT_W = 4,
   parameter int DIGITS  = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        load,
   input  logic [DIGITS*DIGIT_W-1:0]   load_val,
   input  logic                        increment,
   input  logic                        decrement,
   output logic [DIGITS*DIGIT_W-1:0]   count,
   output logic                        ro,
   output logic                        bo,
   output logic                        at_zero
`ifdef CHAIN_COUNT_SAT_EN
   ,
   output logic                        sat
`endif
);

   localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(M_PARAM - 1);

   logic [DIGITS-1:0][DIGIT_W-1:0] cnt;
   logic [DIGITS-1:0][DIGIT_W-1:0] nxt;
   logic [DIGITS-1:0][DIGIT_W-1:0] ld_val;
   logic up;
   logic dn;
   logic all_max;
   logic all_zero;
   logic hold;

   assign up = increment & ~decrement;
   assign dn = decrement & ~increment;

   always_comb begin
      all_max  = 1'b1;
      all_zero = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         all_max  = all_max & (cnt[i] == MAX_D);
         all_zero = all_zero & (cnt[i] == '0);
      end
   end

   // Per-digit clamp of out-of-range load fields to M_PARAM-1.
   always_comb begin
      logic [DIGIT_W-1:0] f;
      ld_val = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         f = load_val[i*DIGIT_W +: DIGIT_W];
         if ({1'b0, f} >= (DIGIT_W+1)'(M_PARAM))
            ld_val[i] = MAX_D;
         else
            ld_val[i] = f;
      end
   end

   // Single-cycle ripple: a digit steps only while every lower digit sits at its edge value.
   always_comb begin
      logic up_rip;
      logic dn_rip;
      nxt    = cnt;
      up_rip = up;
      dn_rip = dn;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (up_rip)
            nxt[i] = (cnt[i] == MAX_D) ? '0 : cnt[i] + 1'b1;
         else if (dn_rip)
            nxt[i] = (cnt[i] == '0) ? MAX_D : cnt[i] - 1'b1;
         up_rip = up_rip & (cnt[i] == MAX_D);
         dn_rip = dn_rip & (cnt[i] == '0);
      end
   end

   assign ro      = all_max & up & ~clear & ~load;
   assign bo      = all_zero & dn & ~clear & ~load;
   assign at_zero = all_zero;
   assign count   = cnt;

`ifdef CHAIN_COUNT_SAT_EN
   assign hold = ro | bo;
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (load)
         cnt <= ld_val;
      else if (!hold)
         cnt <= nxt;
   end

`ifdef CHAIN_COUNT_SAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sat <= 1'b0;
      else if (clear || load)
         sat <= 1'b0;
      else if (hold)
         sat <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_chain_count.sv
// Directed bench for chain_count (DIGITS=2, BCD), using a decimal reference model and a queue of expected counts.
module tb_chain_count;

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic       load;
   logic [7:0] load_val;
   logic       increment;
   logic       decrement;
   logic [7:0] count;
   logic       ro;
   logic       bo;
   logic       at_zero;
`ifdef CHAIN_COUNT_SAT_EN
   logic       sat;
   int         sm = 0;
`endif

   int         n_chk  = 0;
   int         n_fail = 0;
   int         m      = 0;
   logic [7:0] exp_q[$];

   chain_count #(.M_PARAM(10), .DIGIT_W(4), .DIGITS(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .load      (load),
      .load_val  (load_val),
      .increment (increment),
      .decrement (decrement),
      .count     (count),
      .ro        (ro),
      .bo        (bo),
      .at_zero   (at_zero)
`ifdef CHAIN_COUNT_SAT_EN
      ,
      .sat       (sat)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check combinational ro/bo, then check the registered result after the edge.
   task automatic step(input logic c, input logic l, input logic [7:0] lv, input logic i, input logic d);
      logic up;
      logic dn;
      logic held;
      int   nxt;
      int   hi;
      int   lo;
      clear = c; load = l; load_val = lv; increment = i; decrement = d;
      up = i & ~d;
      dn = d & ~i;
      #1;
      check("ro", 16'(ro), 16'((m == 99) && up && !c && !l));
      check("bo", 16'(bo), 16'((m == 0) && dn && !c && !l));
      held = 1'b0;
      if (c) begin
         nxt = 0;
      end else if (l) begin
         hi  = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
         lo  = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
         nxt = hi * 10 + lo;
      end else if (up) begin
         nxt  = (m + 1) % 100;
         held = (m == 99);
      end else if (dn) begin
         nxt  = (m + 99) % 100;
         held = (m == 0);
      end else begin
         nxt = m;
      end
`ifdef CHAIN_COUNT_SAT_EN
      if (held) nxt = m;
      if (c || l) sm = 0;
      else if (held) sm = 1;
`endif
      exp_q.push_back(to_bcd(nxt));
      @(posedge clk);
      #1;
      m = nxt;
      check("count", 16'(count), 16'(exp_q.pop_front()));
      check("at_zero", 16'(at_zero), 16'(m == 0));
`ifdef CHAIN_COUNT_SAT_EN
      check("sat", 16'(sat), 16'(sm));
`endif
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
      increment = 1'b0; decrement = 1'b0;
      #12;
      check("reset_count", 16'(count), 16'h0000);
      check("reset_at_zero", 16'(at_zero), 16'h0001);
      check("reset_ro", 16'(ro), 16'h0000);
      check("reset_bo", 16'(bo), 16'h0000);
      reset = 1'b0;

      // count up 0 -> 10 -> 99
      for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("count_10", 16'(count), 16'h0010);
      for (int k = 0; k < 89; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("count_99", 16'(count), 16'h0099);

      // rollover at max, then idle
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // borrow at zero, then 40 -> 39
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // priority, clamp and both-requests hold
      step(1'b0, 1'b1, 8'hC5, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'hAF, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h09, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // asynchronous reset mid-count, overlapping a load
      step(1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("count_37", 16'(count), 16'h0037);
      #2;
      load = 1'b1; load_val = 8'h55; increment = 1'b0; decrement = 1'b0;
      reset = 1'b1;
      #1;
      check("async_reset_count", 16'(count), 16'h0000);
      check("async_reset_at_zero", 16'(at_zero), 16'h0001);
      @(posedge clk);
      #1;
      check("reset_over_load", 16'(count), 16'h0000);
      reset = 1'b0; load = 1'b0;
      m = 0;
`ifdef CHAIN_COUNT_SAT_EN
      sm = 0;
`endif
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // randomised steps against the model
      for (int k = 0; k < 60; k++)
         step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
              8'($urandom), 1'($urandom), 1'($urandom));

      // end-of-range behaviour, then recovery via load
      step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/chain_count.md
Name: chain_count

Overview:
- Parametrised multi-digit modulo up/down counter. It replaces the single-digit rollover counter in the timer/connector path.
- Holds DIGITS cascaded digits, each counting modulo M_PARAM, with an internal ripple carry/borrow between digits.
- Supports synchronous clear, parallel load, up and down counting, and whole-chain rollover/borrow outputs that cascade into further chain_count instances or timer logic.

Parameters:
- M_PARAM, 10, modulus of each digit; legal range 2 to 2**DIGIT_W.
- DIGIT_W, 4, bits per digit.
- DIGITS, 4, number of cascaded digits; digit 0 is the least significant.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of all digits to 0.
- load  input  1  synchronous parallel load from load_val.
- load_val  input  DIGITS*DIGIT_W  load value; digit i in bits [i*DIGIT_W +: DIGIT_W].
- increment  input  1  count-up request for this cycle.
- decrement  input  1  count-down request for this cycle.
- count  output  DIGITS*DIGIT_W  registered digit values, same packing as load_val.
- ro  output  1  combinational rollover: chain at max and an effective up step this cycle.
- bo  output  1  combinational borrow: chain at zero and an effective down step this cycle.
- at_zero  output  1  combinational; high when all digits are 0.

Behaviour:
- Reset: reset high forces every digit to 0 immediately, independent of clk. count=0 and at_zero=1; ro=0 and bo=0 unless the inputs request a step (see below).
- Priority per posedge: clear > load > step.
- Effective step:
  - up = increment & ~decrement.
  - down = decrement & ~increment.
  - Both high, or both low: count holds.
- Clear: all digits become 0 next cycle. load and step are ignored that cycle.
- Load:
  - Each digit takes its load_val field.
  - A field >= M_PARAM is clamped to M_PARAM-1, independently per digit.
  - Step is ignored that cycle.
- Up step:
  - Digit 0 adds 1.
  - Digit i (i>0) adds 1 only if every lower digit equals M_PARAM-1.
  - A digit at M_PARAM-1 that receives a carry wraps to 0.
  - Carry resolves within one cycle (combinational ripple, no pipelining). Latency from request to updated count is 1 clock.
- Down step:
  - Digit 0 subtracts 1.
  - Digit i (i>0) subtracts 1 only if every lower digit equals 0.
  - A digit at 0 that receives a borrow wraps to M_PARAM-1.
- Rollover/borrow outputs:
  - ro = (all digits == M_PARAM-1) & up & ~clear & ~load.
  - bo = (all digits == 0) & down & ~clear & ~load.
  - Both are same-cycle combinational, for cascading into the next instance's increment/decrement.
  - ro and bo are never high together.
- Wrap-around: an up step at all-max gives all-zero next cycle (ro high during the step cycle). A down step at all-zero gives all-max next cycle (bo high).
- Digit values >= M_PARAM are unreachable; only reset, clear, load and step paths write digits.
- Reset mid-operation: reset asserted on the same cycle as a load or step discards that operation. Release on the next posedge resumes normal priority.
- Arithmetic is per-digit modulo M_PARAM, DIGIT_W wide. With M_PARAM=10 and DIGIT_W=4, count is BCD.

Optional Feature:
- Macro: CHAIN_COUNT_SAT_EN.
- Defined:
  - An up step at all-max holds all-max; a down step at all-zero holds zero. The chain never wraps.
  - ro and bo still assert on the attempted step, unchanged.
  - Adds output sat (1 bit, registered, reset 0). sat is set on any held step, cleared by clear or load, and otherwise held.
- Undefined: wrap behaviour as in Behaviour; no sat port.

Test Plan (DIGITS=2, M_PARAM=10, DIGIT_W=4):
- Reset asserted mid-count at count=8'h37, no clk edge -> count=8'h00 immediately, at_zero=1.
- Count up: increment=1 for 10 cycles from 0 -> count=8'h10. After 99 total cycles, count=8'h99.
- Wrap: at 8'h99 with increment=1 -> ro=1 in that cycle; next cycle count=8'h00, ro=0.
- Borrow: at 8'h00 with decrement=1 -> bo=1; next cycle count=8'h99. Then decrement from 8'h40 -> 8'h39.
- Priority and clamp:
  - load=1, load_val=8'hC5, increment=1 -> count=8'h95.
  - clear=1 and load=1 together -> count=8'h00.
  - increment=decrement=1 at 8'h42 -> holds 8'h42, ro=bo=0.
- With CHAIN_COUNT_SAT_EN: increment at 8'h99 -> ro=1, count stays 8'h99, sat=1 next cycle. A following load clears sat.
